// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types, constants and helpers for the bus arbiter
//
// Contents:
//   arb_state_t : arbiter FSM states (IDLE, GRANT, TURN)
//   BANK_W      : width of one per-master bank (offset) field
//   rotl()      : rotate-left of the low w bits of an up-to-ROT_MAX-bit vector
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int BANK_W    = 3;
  localparam int ROT_MAX   = 8;
  localparam int ROT_IDX_W = 3;

  // Bit i of v moves to bit (i+sh) mod w; bits at or above w are returned as 0.
  function automatic logic [ROT_MAX-1:0] rotl(input logic [ROT_MAX-1:0] v,
                                              input int sh,
                                              input int w);
    logic [ROT_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < ROT_MAX; i++) begin
      if (i < w) r[ROT_IDX_W'((i + sh) % w)] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker
//
// Ports:
//   req    in  N      request vector
//   start  in  SEL_W  index searched first; search wraps through N-1 back to 0
//   winner out SEL_W  first requesting index at or after start
//   valid  out 1      any request present
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] winner,
  output logic             valid
);

  logic [ROT_MAX-1:0] rot;

  // Rotating left by N-start lands req[start] on bit 0, so the lowest set
  // bit of rot is the first requester in search order.
  always_comb begin
    rot    = rotl(ROT_MAX'(req), (N - int'(start)) % N, N);
    valid  = 1'b0;
    winner = start;
    for (int j = ROT_MAX - 1; j >= 0; j--) begin
      if (rot[j]) begin
        valid  = 1'b1;
        winner = SEL_W'((int'(start) + j) % N);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin owner arbiter for the shared tri-state bus
//
// Ports:
//   clk         in  1              system clock
//   reset       in  1              asynchronous active-high reset
//   req         in  NUM_MASTERS    per-master level request
//   out_en      out NUM_MASTERS    one-hot-or-zero bus drive enable
//   rdy         out NUM_MASTERS    per-master RDY, identical to out_en
//   offset      out 3*NUM_MASTERS  per-master bank, slice [3i+2:3i] is master i
//   owner       out SEL_W          current or most recent owner
//   busy        out 1              some master is driving the bus
//   cfg_we      in  1              bank register write strobe
//   cfg_sel     in  SEL_W          master whose bank is written
//   cfg_offset  in  3              bank value written
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_BURST   = 16,
  parameter int TURNAROUND  = 1,
  parameter int SEL_W       = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        req,
  output logic [NUM_MASTERS-1:0]        out_en,
  output logic [NUM_MASTERS-1:0]        rdy,
  output logic [BANK_W*NUM_MASTERS-1:0] offset,
  output logic [SEL_W-1:0]              owner,
  output logic                          busy,
  input  logic                          cfg_we,
  input  logic [SEL_W-1:0]              cfg_sel,
  input  logic [BANK_W-1:0]             cfg_offset
);

  // One spare bit above MAX_BURST-1 so the counter can saturate past the limit.
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) + 1 : 1;
  localparam int TURN_W  = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam logic [TURN_W-1:0]  TURN_LOAD  = TURN_W'(TURNAROUND - 1);
  localparam logic [SEL_W-1:0]   LAST_IDX   = SEL_W'(NUM_MASTERS - 1);

  arb_state_t             state, state_n;
  logic [SEL_W-1:0]       owner_n;
  logic [NUM_MASTERS-1:0] out_en_n;
  logic [BURST_W-1:0]     burst_cnt, burst_n;
  logic [TURN_W-1:0]      turn_cnt, turn_n;

  logic [SEL_W-1:0]       pick_start, pick_idx;
  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic                   owner_req, other_req, burst_hit;

  // Search begins just past the last owner, so it is served last.
  assign pick_start = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  rr_picker #(
    .N     (NUM_MASTERS),
    .SEL_W (SEL_W)
  ) u_pick (
    .req    (req),
    .start  (pick_start),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign pick_onehot = NUM_MASTERS'(1) << pick_idx;

  // In GRANT out_en is the owner's one-hot, so it doubles as the owner mask.
  assign owner_req = |(req & out_en);
  assign other_req = |(req & ~out_en);
  assign burst_hit = (MAX_BURST != 0) && (burst_cnt == BURST_LAST);

  assign rdy = out_en;

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    out_en_n = out_en;
    burst_n  = burst_cnt;
    turn_n   = turn_cnt;
    case (state)
      IDLE: begin
        out_en_n = '0;
        if (pick_valid) begin
          out_en_n = pick_onehot;
          owner_n  = pick_idx;
          burst_n  = '0;
          state_n  = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req || (burst_hit && other_req)) begin
          out_en_n = '0;
          turn_n   = TURN_LOAD;
          state_n  = TURN;
        end else if (burst_cnt != '1) begin
          burst_n = burst_cnt + 1'b1;
        end
      end
      TURN: begin
        out_en_n = '0;
        if (turn_cnt == '0) begin
          if (pick_valid) begin
            out_en_n = pick_onehot;
            owner_n  = pick_idx;
            burst_n  = '0;
            state_n  = GRANT;
          end else begin
            state_n = IDLE;
          end
        end else begin
          turn_n = turn_cnt - 1'b1;
        end
      end
      default: begin
        out_en_n = '0;
        state_n  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= LAST_IDX;
      out_en    <= '0;
      busy      <= 1'b0;
      burst_cnt <= '0;
      turn_cnt  <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      out_en    <= out_en_n;
      busy      <= |out_en_n;
      burst_cnt <= burst_n;
      turn_cnt  <= turn_n;
    end
  end

  // Bank register file; out-of-range selects are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        offset[i*BANK_W +: BANK_W] <= BANK_W'(i);
      end
    end else if (cfg_we && (int'(cfg_sel) < NUM_MASTERS)) begin
      offset[int'(cfg_sel)*BANK_W +: BANK_W] <= cfg_offset;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter, turnaround 1 and 2 instances
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_sel = '0;
  logic [2:0]  cfg_offset = '0;

  logic [3:0]  out_en_a, rdy_a, out_en_b, rdy_b;
  logic [11:0] offset_a, offset_b;
  logic [2:0]  owner_a, owner_b;
  logic        busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] exp;
    string      tag;
  } ent_t;

  ent_t q_a[$];
  ent_t q_b[$];

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(4), .MAX_BURST(16), .TURNAROUND(1), .SEL_W(3)) u_a (
    .clk(clk), .reset(reset), .req(req), .out_en(out_en_a), .rdy(rdy_a),
    .offset(offset_a), .owner(owner_a), .busy(busy_a),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_offset(cfg_offset)
  );

  bus_arbiter #(.NUM_MASTERS(4), .MAX_BURST(16), .TURNAROUND(2), .SEL_W(3)) u_b (
    .clk(clk), .reset(reset), .req(req), .out_en(out_en_b), .rdy(rdy_b),
    .offset(offset_b), .owner(owner_b), .busy(busy_b),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_offset(cfg_offset)
  );

  task automatic check_vec(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [3:0] exp, input int n, input string tag);
    ent_t e;
    e.exp = exp;
    e.tag = tag;
    for (int i = 0; i < n; i++) q_a.push_back(e);
  endtask

  task automatic push_b(input logic [3:0] exp, input int n, input string tag);
    ent_t e;
    e.exp = exp;
    e.tag = tag;
    for (int i = 0; i < n; i++) q_b.push_back(e);
  endtask

  task automatic push_ab(input logic [3:0] exp, input int n, input string tag);
    push_a(exp, n, tag);
    push_b(exp, n, tag);
  endtask

  // One entry per cycle is popped at the falling edge; invariants every cycle.
  task automatic tick(input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check_vec({e.tag, "_a"}, 12'(out_en_a), 12'(e.exp));
      end
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check_vec({e.tag, "_b"}, 12'(out_en_b), 12'(e.exp));
      end
      check_vec("onehot_a", 12'($onehot0(out_en_a)), 12'(1));
      check_vec("onehot_b", 12'($onehot0(out_en_b)), 12'(1));
      check_vec("rdy_a", 12'(rdy_a), 12'(out_en_a));
      check_vec("rdy_b", 12'(rdy_b), 12'(out_en_b));
      check_vec("busy_a", 12'(busy_a), 12'(|out_en_a));
      check_vec("busy_b", 12'(busy_b), 12'(|out_en_b));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset values
    tick(2);
    check_vec("rst_out_en_a", 12'(out_en_a), 12'h0);
    check_vec("rst_out_en_b", 12'(out_en_b), 12'h0);
    check_vec("rst_owner_a", 12'(owner_a), 12'h3);
    check_vec("rst_owner_b", 12'(owner_b), 12'h3);
    check_vec("rst_offset_a", offset_a, 12'h688);
    check_vec("rst_offset_b", offset_b, 12'h688);
    reset = 1'b0;
    tick(1);

    // First grant from IDLE takes one cycle
    req = 4'b0001;
    push_ab(4'b0000, 1, "first_idle");
    push_ab(4'b0001, 3, "first_grant");
    tick(4);
    check_vec("first_owner_a", 12'(owner_a), 12'h0);
    check_vec("first_owner_b", 12'(owner_b), 12'h0);
    check_vec("first_offset_a", offset_a, 12'h688);
    req = 4'b0000;
    push_ab(4'b0001, 1, "first_hold");
    push_ab(4'b0000, 4, "first_release");
    tick(5);

    // All request: 16-cycle tenures in order 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    push_ab(4'b0000, 1, "rr_idle");
    for (int m = 0; m < 4; m++) begin
      push_a(4'(1 << m), 16, "rr_tenure");
      push_a(4'b0000, 1, "rr_gap");
      push_b(4'(1 << m), 16, "rr_tenure");
      push_b(4'b0000, 2, "rr_gap");
    end
    push_a(4'b0001, 8, "rr_wrap");
    push_b(4'b0001, 4, "rr_wrap");
    tick(77);

    // Lone requester is never burst-released
    do_reset();
    req = 4'b0100;
    push_ab(4'b0000, 1, "solo_idle");
    push_ab(4'b0100, 100, "solo_hold");
    tick(101);
    check_vec("solo_owner_a", 12'(owner_a), 12'h2);
    check_vec("solo_owner_b", 12'(owner_b), 12'h2);

    // Owner 1 drops with master 3 waiting
    do_reset();
    req = 4'b0010;
    push_ab(4'b0000, 1, "drop_idle");
    push_ab(4'b0010, 3, "drop_own1");
    tick(4);
    req = 4'b1010;
    push_ab(4'b0010, 3, "drop_wait3");
    tick(3);
    req = 4'b1000;
    push_ab(4'b0010, 1, "drop_last");
    push_a(4'b0000, 1, "drop_turn");
    push_a(4'b1000, 3, "drop_new");
    push_b(4'b0000, 2, "drop_turn");
    push_b(4'b1000, 2, "drop_new");
    tick(5);
    check_vec("drop_owner_a", 12'(owner_a), 12'h3);
    check_vec("drop_owner_b", 12'(owner_b), 12'h3);

    // One-cycle req glitch still ends the tenure
    req = 4'b0000;
    push_ab(4'b1000, 1, "glitch_last");
    tick(1);
    req = 4'b1000;
    push_a(4'b0000, 1, "glitch_turn");
    push_a(4'b1000, 3, "glitch_regrant");
    push_b(4'b0000, 2, "glitch_turn");
    push_b(4'b1000, 2, "glitch_regrant");
    tick(4);

    // Config port
    do_reset();
    cfg_we = 1'b1;
    cfg_sel = 3'd1;
    cfg_offset = 3'd5;
    check_vec("cfg_before_a", offset_a, 12'h688);
    tick(1);
    check_vec("cfg_sel1_a", offset_a, 12'h6A8);
    check_vec("cfg_sel1_b", offset_b, 12'h6A8);
    cfg_sel = 3'd7;
    cfg_offset = 3'd6;
    tick(1);
    check_vec("cfg_sel7_a", offset_a, 12'h6A8);
    cfg_sel = 3'd4;
    tick(1);
    check_vec("cfg_sel4_a", offset_a, 12'h6A8);
    cfg_sel = 3'd3;
    cfg_offset = 3'd7;
    tick(1);
    check_vec("cfg_sel3_a", offset_a, 12'hEA8);
    check_vec("cfg_sel3_b", offset_b, 12'hEA8);
    cfg_we = 1'b0;
    tick(1);

    // Reset mid-grant drops out_en asynchronously
    req = 4'b1000;
    push_ab(4'b0000, 1, "mid_idle");
    push_ab(4'b1000, 3, "mid_grant");
    tick(4);
    check_vec("mid_owner_a", 12'(owner_a), 12'h3);
    reset = 1'b1;
    #1;
    check_vec("async_out_en_a", 12'(out_en_a), 12'h0);
    check_vec("async_out_en_b", 12'(out_en_b), 12'h0);
    check_vec("async_rdy_a", 12'(rdy_a), 12'h0);
    check_vec("async_rdy_b", 12'(rdy_b), 12'h0);
    check_vec("async_busy_a", 12'(busy_a), 12'h0);
    check_vec("async_offset_a", offset_a, 12'h688);
    tick(2);
    reset = 1'b0;
    push_ab(4'b0000, 1, "post_rst_idle");
    push_ab(4'b1000, 3, "post_rst_grant");
    tick(4);
    check_vec("post_rst_owner_a", 12'(owner_a), 12'h3);
    check_vec("post_rst_owner_b", 12'(owner_b), 12'h3);

    check_vec("queue_drain", 12'(q_a.size() + q_b.size()), 12'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
